clock_set_controller: RTL and testbench

CLOCK_SET_CONTROLLER -- requirements
Module: clock_set_controller

---
 rtl/clock_set_controller.sv | 212 +++++++++++++++++++++
 tb/tb_clock_set_controller.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/clock_set_controller.sv
// Button-driven setup controller for a clock/calendar: debounces four buttons and
// sequences field selection, inc/dec pulses, blink and timeout. Optional macro: CLOCK_SET_AUTO_REPEAT_EN.
module clock_set_controller #(
    parameter int DEBOUNCE_MS     = 20,
    parameter int REPEAT_DELAY_MS = 500,
    parameter int REPEAT_RATE_MS  = 100,
    parameter int TIMEOUT_S       = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1ms,
    input  logic       tick_1s,
    input  logic       btn_mode,
    input  logic       btn_next,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic       set_mode,
    output logic [2:0] field_sel,
    output logic       inc,
    output logic       dec,
    output logic       blink
);

    // state | meaning
    // RUN   | normal timekeeping, buttons other than mode ignored
    // SET   | setup mode, field_sel selects the field being edited
    typedef enum logic {RUN = 1'b0, SET = 1'b1} state_t;

    localparam int DB_W     = $clog2(DEBOUNCE_MS + 1);
    localparam int TO_W     = $clog2(TIMEOUT_S + 1);
    localparam int BLINK_MS = 500;
    localparam int BL_W     = $clog2(BLINK_MS);

    // Button index: 0 mode, 1 next, 2 up, 3 down
    logic [3:0]      btn_raw;
    logic [3:0]      sync1_q, sync2_q;
    logic [3:0]      deb_q, deb_d, deb_prev_q;
    logic [DB_W-1:0] db_cnt_q [4];
    logic [DB_W-1:0] db_cnt_d [4];
    logic [3:0]      press;

    state_t          state_q, state_d;
    logic [2:0]      field_q, field_d;
    logic            inc_q, inc_d, dec_q, dec_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            blink_q, blink_d;
    logic [BL_W-1:0] bl_cnt_q, bl_cnt_d;
    logic            rep_up, rep_dn;
    logic            activity, timeout_hit, up_ev, dn_ev;

    assign btn_raw = {btn_down, btn_up, btn_next, btn_mode};

    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < 4; i++) begin
            db_cnt_d[i] = db_cnt_q[i];
            if (sync2_q[i] == deb_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (tick_1ms) begin
                if (db_cnt_q[i] == DB_W'(DEBOUNCE_MS - 1)) begin
                    deb_d[i]    = sync2_q[i];
                    db_cnt_d[i] = '0;
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Edge detection only on rising debounced level, so a held button never re-fires
    assign press = deb_q & ~deb_prev_q;

`ifdef CLOCK_SET_AUTO_REPEAT_EN
    localparam int RP_MAX = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ? REPEAT_DELAY_MS : REPEAT_RATE_MS;
    localparam int RP_W   = $clog2(RP_MAX + 1);

    logic [RP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic            rep_hold, rep_fire;

    assign rep_hold = (state_q == SET) && (deb_q[2] ^ deb_q[3]);

    // A zero count means idle: a button already held when SET is entered never repeats
    always_comb begin
        rep_cnt_d = rep_cnt_q;
        rep_fire  = 1'b0;
        if (!rep_hold) begin
            rep_cnt_d = '0;
        end else if (press[2] || press[3]) begin
            rep_cnt_d = RP_W'(REPEAT_DELAY_MS);
        end else if (tick_1ms && (rep_cnt_q != '0)) begin
            if (rep_cnt_q == RP_W'(1)) begin
                rep_fire  = 1'b1;
                rep_cnt_d = RP_W'(REPEAT_RATE_MS);
            end else begin
                rep_cnt_d = rep_cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rep_cnt_q <= '0;
        else     rep_cnt_q <= rep_cnt_d;
    end

    assign rep_up = rep_fire & deb_q[2];
    assign rep_dn = rep_fire & deb_q[3];
`else
    assign rep_up = 1'b0;
    assign rep_dn = 1'b0;
`endif

    assign activity    = (|press) | rep_up | rep_dn;
    assign timeout_hit = tick_1s && (to_cnt_q == TO_W'(TIMEOUT_S - 1)) && !activity;
    assign up_ev       = press[2] | rep_up;
    assign dn_ev       = press[3] | rep_dn;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        field_d = field_q;
        inc_d   = 1'b0;
        dec_d   = 1'b0;
        case (state_q)
            RUN: begin
                if (press[0]) begin
                    state_d = SET;
                    field_d = 3'd0;
                end
            end
            SET: begin
                if (press[0] || timeout_hit) begin
                    state_d = RUN;
                    field_d = 3'd0;
                end else if (press[1]) begin
                    field_d = (field_q >= 3'd5) ? 3'd0 : field_q + 3'd1;
                end else begin
                    inc_d = up_ev & ~dn_ev;
                    dec_d = dn_ev & ~up_ev;
                end
            end
            default: begin
                state_d = RUN;
                field_d = 3'd0;
            end
        endcase
    end

    always_comb begin
        to_cnt_d = '0;
        bl_cnt_d = '0;
        blink_d  = 1'b0;
        if ((state_q == SET) && (state_d == SET)) begin
            if (!activity && tick_1s) to_cnt_d = to_cnt_q + 1'b1;
            else if (!activity)       to_cnt_d = to_cnt_q;
            blink_d  = blink_q;
            bl_cnt_d = bl_cnt_q;
            if (tick_1ms) begin
                if (bl_cnt_q == '0) begin
                    blink_d  = ~blink_q;
                    bl_cnt_d = BL_W'(BLINK_MS - 1);
                end else begin
                    bl_cnt_d = bl_cnt_q - 1'b1;
                end
            end
        end else if (state_d == SET) begin
            blink_d  = 1'b1;
            bl_cnt_d = BL_W'(BLINK_MS - 1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
            field_q    <= 3'd0;
            inc_q      <= 1'b0;
            dec_q      <= 1'b0;
            to_cnt_q   <= '0;
            blink_q    <= 1'b0;
            bl_cnt_q   <= '0;
        end else begin
            sync1_q    <= btn_raw;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= db_cnt_d[i];
            field_q    <= field_d;
            inc_q      <= inc_d;
            dec_q      <= dec_d;
            to_cnt_q   <= to_cnt_d;
            blink_q    <= blink_d;
            bl_cnt_q   <= bl_cnt_d;
        end
    end

    // A pending pulse is dropped if the state changes in the cycle it would appear
    always_comb begin
        set_mode  = (state_q == SET);
        field_sel = field_q;
        inc       = inc_q & set_mode & (state_d == state_q);
        dec       = dec_q & set_mode & (state_d == state_q);
        blink     = blink_q & set_mode;
    end

endmodule

// File: tb/tb_clock_set_controller.sv
// Scoreboard bench for clock_set_controller: expected output events are queued by the
// stimulus and popped by a monitor whenever inc/dec pulse or set_mode/field_sel change.
module tb_clock_set_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_1ms = 1'b0;
    logic       tick_1s = 1'b0;
    logic       btn_mode = 1'b0, btn_next = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
    logic       set_mode, inc, dec, blink;
    logic [2:0] field_sel;

    int checks = 0;
    int errors = 0;

    // Event encoding: {inc, dec, set_mode, field_sel}
    logic [5:0] exp_q[$];

    clock_set_controller dut (
        .clk       (clk),
        .rst       (rst),
        .tick_1ms  (tick_1ms),
        .tick_1s   (tick_1s),
        .btn_mode  (btn_mode),
        .btn_next  (btn_next),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .set_mode  (set_mode),
        .field_sel (field_sel),
        .inc       (inc),
        .dec       (dec),
        .blink     (blink)
    );

    always #5 clk = ~clk;

    // One millisecond is four clocks here
    int ms_div = 0;
    always @(negedge clk) begin
        ms_div   = (ms_div + 1) % 4;
        tick_1ms = (ms_div == 0);
    end

    logic       prev_sm = 1'b0;
    logic [2:0] prev_f  = 3'd0;
    logic [5:0] cur, e;
    always @(negedge clk) begin
        if (!rst) begin
            cur = {inc, dec, set_mode, field_sel};
            if (inc || dec || (set_mode != prev_sm) || (field_sel != prev_f)) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event got=%b required=none", cur);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        errors++;
                        $display("FAIL event got=%b required=%b", cur, e);
                    end
                end
            end
        end
        prev_sm = set_mode;
        prev_f  = field_sel;
    end

    task automatic check(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s got=%0d required=%0d", name, got, req);
        end
    endtask

    task automatic wait_ms(input int n);
        repeat (4 * n) @(negedge clk);
    endtask

    task automatic set_btns(input logic [3:0] m);
        btn_mode = m[0];
        btn_next = m[1];
        btn_up   = m[2];
        btn_down = m[3];
    endtask

    task automatic press(input logic [3:0] m, input int hold_ms);
        set_btns(m);
        wait_ms(hold_ms);
        set_btns(4'b0000);
        wait_ms(40);
    endtask

    task automatic pulse_1s(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) tick_1s = 1'b1;
            @(negedge clk) tick_1s = 1'b0;
            repeat (2) @(negedge clk);
        end
    endtask

    localparam logic [3:0] B_MODE = 4'b0001;
    localparam logic [3:0] B_NEXT = 4'b0010;
    localparam logic [3:0] B_UP   = 4'b0100;
    localparam logic [3:0] B_DOWN = 4'b1000;

    int n_rep;

    initial begin
        repeat (5) @(negedge clk);
        check("reset_set_mode", set_mode, 0);
        check("reset_field_sel", field_sel, 0);
        check("reset_inc", inc, 0);
        check("reset_dec", dec, 0);
        check("reset_blink", blink, 0);
        rst = 1'b0;
        wait_ms(5);

        // Bouncing mode button settles to a single press
        exp_q.push_back(6'b00_1_000);
        for (int i = 0; i < 5; i++) begin
            btn_mode = (i % 2 == 0);
            wait_ms(3);
        end
        btn_mode = 1'b1;
        wait_ms(25);
        btn_mode = 1'b0;
        wait_ms(30);
        check("bounce_set_mode", set_mode, 1);
        check("blink_on_entry", blink, 1);
        wait_ms(600);
        check("blink_toggled", blink, 0);

        for (int k = 1; k <= 7; k++) begin
            exp_q.push_back({3'b001, 3'(k % 6)});
            press(B_NEXT, 30);
        end
        check("field_after_cycle", field_sel, 1);

        exp_q.push_back(6'b00_1_010);
        press(B_NEXT, 30);
        exp_q.push_back(6'b10_1_010);
        press(B_UP, 30);

        // Mode outranks next in the same cycle
        exp_q.push_back(6'b00_0_000);
        press(B_MODE | B_NEXT, 30);
        check("mode_next_set_mode", set_mode, 0);

        press(B_UP, 30);

        exp_q.push_back(6'b00_1_000);
        press(B_MODE, 30);
        press(B_UP | B_DOWN, 30);

`ifdef CLOCK_SET_AUTO_REPEAT_EN
        n_rep = 7;
`else
        n_rep = 1;
`endif
        for (int i = 0; i < n_rep; i++) exp_q.push_back(6'b10_1_000);
        press(B_UP, 1050);

        exp_q.push_back(6'b01_1_000);
        press(B_DOWN, 30);

        for (int k = 1; k <= 4; k++) begin
            exp_q.push_back({3'b001, 3'(k)});
            press(B_NEXT, 30);
        end
        pulse_1s(29);
        check("timeout_29_ticks", set_mode, 1);
        exp_q.push_back(6'b10_1_100);
        press(B_UP, 30);
        pulse_1s(29);
        check("timeout_restarted", set_mode, 1);
        exp_q.push_back(6'b00_0_000);
        pulse_1s(1);
        check("timeout_set_mode", set_mode, 0);
        check("timeout_field_sel", field_sel, 0);

        // Reset while in SET with an up press mid-debounce
        exp_q.push_back(6'b00_1_000);
        press(B_MODE, 30);
        btn_up = 1'b1;
        wait_ms(10);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mid_set_mode", set_mode, 0);
        check("rst_mid_blink", blink, 0);
        check("rst_mid_inc", inc, 0);
        btn_up = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_ms(60);
        check("after_rst_set_mode", set_mode, 0);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
